// File: rtl/mem_port_arbiter.sv
// Arbitrates one memory port between IF and MEM-stage data accesses.
// Define ARB_PERF_CNT_EN to add transaction and stall performance counters.
module mem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_valid,
  input  logic              dm_req,
  input  logic              dm_we,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  input  logic [3:0]        dm_be,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_valid,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              err
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_if_cnt,
  output logic [31:0]       perf_dm_cnt,
  output logic [31:0]       perf_stall_cnt
`endif
);

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] WAIT_LAST = CW'(MAX_WAIT - 1);
  localparam logic [DATA_W-1:0] NOP = DATA_W'(32'h0000_0013);

  typedef enum logic [1:0] {
    IDLE,
    DM_BUSY,
    IF_BUSY
  } state_t;

  state_t        state;
  logic [CW-1:0] wait_cnt;
  logic          dm_go;
  logic          if_go;
  logic          done;

  // A requester is masked in its own valid cycle so it cannot re-win at once
  assign dm_go = dm_req & ~dm_valid;
  assign if_go = if_req & ~if_valid;
  assign stall = (if_req & ~if_valid) | (dm_req & ~dm_valid);
  assign done  = mem_ack | (wait_cnt == WAIT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wait_cnt  <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      if_rdata  <= '0;
      if_valid  <= 1'b0;
      dm_rdata  <= '0;
      dm_valid  <= 1'b0;
      err       <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      dm_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          wait_cnt <= '0;
          if (dm_go) begin
            state     <= DM_BUSY;
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_be    <= dm_be;
          end else if (if_go) begin
            state     <= IF_BUSY;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= '0;
            mem_be    <= 4'b1111;
          end
        end
        DM_BUSY: begin
          if (done) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            wait_cnt <= '0;
            dm_valid <= 1'b1;
            if (!mem_we)
              dm_rdata <= mem_ack ? mem_rdata : '0;
            if (!mem_ack)
              err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        IF_BUSY: begin
          if (done) begin
            state    <= IDLE;
            mem_req  <= 1'b0;
            wait_cnt <= '0;
            if_valid <= 1'b1;
            if_rdata <= mem_ack ? mem_rdata : NOP;
            if (!mem_ack)
              err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_if_cnt    <= '0;
      perf_dm_cnt    <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (state == IF_BUSY && done)
        perf_if_cnt <= perf_if_cnt + 1'b1;
      if (state == DM_BUSY && done)
        perf_dm_cnt <= perf_dm_cnt + 1'b1;
      if (stall)
        perf_stall_cnt <= perf_stall_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level
// model with its own byte-enabled memory array.
module tb_mem_port_arbiter;
  localparam int MW = 15;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [3:0]  dm_be;
  logic [31:0] dm_rdata;
  logic        dm_valid;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        err;
`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_cnt;
  logic [31:0] perf_dm_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  always #5 clk = ~clk;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_be(dm_be),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .stall(stall),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .err(err)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_if_cnt(perf_if_cnt),
    .perf_dm_cnt(perf_dm_cnt),
    .perf_stall_cnt(perf_stall_cnt)
`endif
  );

  int checks = 0;
  int failures = 0;

  // memory contents as seen by the reference
  logic [31:0] mem [16];

  // reference: current transaction and expected outputs
  bit          m_busy;
  bit          m_dm;
  bit          m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_be;
  int          m_b;
  int          m_delay;
  bit          e_if_v;
  bit          e_dm_v;
  logic [31:0] e_if_rd;
  logic [31:0] e_dm_rd;
  bit          e_err;
  int          p_if;
  int          p_dm;
  int          p_stall;
  bit          allow_req;

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_dm = 0; m_we = 0; m_b = 0; m_delay = 0;
    m_addr = '0; m_wdata = '0; m_be = '0;
    e_if_v = 0; e_dm_v = 0; e_if_rd = '0; e_dm_rd = '0; e_err = 0;
    p_if = 0; p_dm = 0; p_stall = 0;
  endtask

  task automatic clear_inputs();
    if_req = 0; if_addr = '0;
    dm_req = 0; dm_we = 0; dm_addr = '0; dm_wdata = '0; dm_be = '0;
    mem_ack = 0; mem_rdata = '0;
  endtask

  function automatic int pick_delay();
    int r;
    r = int'($urandom % 8);
    case (r)
      4: return MW - 1;
      5: return MW - 2;
      6: return 1000;
      7: return 1;
      default: return r;
    endcase
  endfunction

  function automatic logic [3:0] pick_be();
    int r;
    r = int'($urandom % 3);
    return (r == 0) ? 4'b1111 : (r == 1) ? 4'b0011 : 4'b0001;
  endfunction

  task automatic finish_txn();
    m_busy = 0;
    if (m_dm) begin e_dm_v = 1; p_dm++; end
    else begin e_if_v = 1; p_if++; end
  endtask

  task automatic step();
    bit pv_if;
    bit pv_dm;
    logic [3:0] idx;
    @(posedge clk);
    #1;
    pv_if = e_if_v;
    pv_dm = e_dm_v;
    if ((if_req && !pv_if) || (dm_req && !pv_dm))
      p_stall++;
    e_if_v = 0;
    e_dm_v = 0;
    if (m_busy) begin
      idx = m_addr[5:2];
      if (mem_ack) begin
        if (m_dm && m_we) begin
          for (int b = 0; b < 4; b++)
            if (m_be[b]) mem[idx][8*b +: 8] = m_wdata[8*b +: 8];
        end else if (m_dm) begin
          e_dm_rd = mem[idx];
        end else begin
          e_if_rd = mem[idx];
        end
        finish_txn();
      end else if (m_b + 1 == MW) begin
        e_err = 1;
        if (!m_dm) e_if_rd = 32'h0000_0013;
        else if (!m_we) e_dm_rd = 32'h0;
        finish_txn();
      end else begin
        m_b++;
      end
    end else if (dm_req && !pv_dm) begin
      m_busy = 1; m_b = 0; m_dm = 1; m_we = dm_we;
      m_addr = dm_addr; m_wdata = dm_wdata; m_be = dm_be;
      m_delay = pick_delay();
    end else if (if_req && !pv_if) begin
      m_busy = 1; m_b = 0; m_dm = 0; m_we = 0;
      m_addr = if_addr; m_wdata = '0; m_be = 4'b1111;
      m_delay = pick_delay();
    end

    check("mem_req", mem_req, m_busy);
    if (m_busy) begin
      check("mem_addr", mem_addr, m_addr);
      check("mem_we", mem_we, m_we);
      check("mem_be", mem_be, m_be);
      if (m_we) check("mem_wdata", mem_wdata, m_wdata);
    end
    check("if_valid", if_valid, e_if_v);
    check("dm_valid", dm_valid, e_dm_v);
    check("if_rdata", if_rdata, e_if_rd);
    check("dm_rdata", dm_rdata, e_dm_rd);
    check("err", err, e_err);
    check("stall", stall,
          (if_req && !e_if_v) || (dm_req && !e_dm_v));
`ifdef ARB_PERF_CNT_EN
    check("perf_if", perf_if_cnt, p_if);
    check("perf_dm", perf_dm_cnt, p_dm);
    check("perf_stall", perf_stall_cnt, p_stall);
`endif

    if (if_req) begin
      if (e_if_v) begin
        if_req = allow_req && ($urandom % 2 == 0);
        if_addr = 32'h100 + ($urandom % 16) * 4;
      end else if (m_busy && !m_dm && $urandom % 16 == 0) begin
        if_req = 0;
      end
    end else if (allow_req && $urandom % 3 == 0) begin
      if_req = 1;
      if_addr = 32'h100 + ($urandom % 16) * 4;
    end
    if (dm_req) begin
      if (e_dm_v) begin
        dm_req = allow_req && ($urandom % 2 == 0);
        dm_we = $urandom % 2;
        dm_addr = 32'h2000 + ($urandom % 16) * 4;
        dm_wdata = $urandom;
        dm_be = pick_be();
      end else if (m_busy && m_dm && $urandom % 16 == 0) begin
        dm_req = 0;
      end
    end else if (allow_req && $urandom % 4 == 0) begin
      dm_req = 1;
      dm_we = $urandom % 2;
      dm_addr = 32'h2000 + ($urandom % 16) * 4;
      dm_wdata = $urandom;
      dm_be = pick_be();
    end
    if (m_busy) begin
      mem_ack = (m_b == m_delay);
      mem_rdata = mem_ack ? mem[m_addr[5:2]] : $urandom;
    end else begin
      mem_ack = ($urandom % 4 == 0);
      mem_rdata = $urandom;
    end
  endtask

  initial begin
    int n;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    clear_inputs();
    model_reset();
    allow_req = 0;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_be", mem_be, 0);
    check("rst_mem_wdata", mem_wdata, 0);

    repeat (10) step();

    allow_req = 1;
    repeat (1500) step();

    n = 0;
    while (!(m_busy && m_dm) && n < 200) begin
      step();
      n++;
    end
    check("dm_busy_reached", m_busy && m_dm, 1);
    rst = 1;
    #1;
    check("async_rst_mem_req", mem_req, 0);
    check("async_rst_dm_valid", dm_valid, 0);
    check("async_rst_err", err, 0);
    clear_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    model_reset();
    allow_req = 0;
    repeat (4) step();

    allow_req = 1;
    repeat (800) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
